// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream Ethernet test frame generator with optional 802.1Q tag
// and an embedded 32-bit sequence number per frame.
module axis_frame_gen #(
  parameter int IFG_CYCLES = 2,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1522
) (
  input  logic         axis_aclk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont_mode,
  input  logic [47:0]  cfg_dst_mac,
  input  logic [47:0]  cfg_src_mac,
  input  logic [15:0]  cfg_ethertype,
  input  logic         cfg_vlan_en,
  input  logic [15:0]  cfg_vlan_tci,
  input  logic [10:0]  cfg_len,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic [31:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         busy,
  output logic         frame_done,
  output logic [31:0]  seq_num
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  // IDLE itself supplies one idle cycle, so GAP covers the remaining IFG_CYCLES-1
  localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES > 1 ? IFG_CYCLES - 2 : 0);
  state_t state, state_n;
  logic launch, hs, fin, vlan;
  logic [5:0] beat, last_beat;
  logic [15:0] gap_cnt, ethertype, tci;
  logic [47:0] dst, src;
  logic [10:0] len, len_c, len_m1, hdr_len;
  logic [31:0] seq;
  logic [255:0] hdr;
  assign hs = m_axis_tvalid & m_axis_tready;
  assign fin = hs & m_axis_tlast;
  assign len_c = cfg_len < 11'(MIN_LEN) ? 11'(MIN_LEN) : cfg_len > 11'(MAX_LEN) ? 11'(MAX_LEN) : cfg_len;
  assign len_m1 = len_c - 11'd1;
  always_comb begin
    state_n = state;
    launch = 1'b0;
    case (state)
      IDLE: begin
        launch = start | cont_mode;
        state_n = launch ? SEND : IDLE;
      end
      SEND: if (fin) begin
        launch = (IFG_CYCLES == 0) && cont_mode;
        state_n = launch ? SEND : IFG_CYCLES > 1 ? GAP : IDLE;
      end
      GAP: state_n = gap_cnt == 16'd0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge axis_aclk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      last_beat <= '0;
      gap_cnt <= '0;
      frame_done <= 1'b0;
      seq_num <= '0;
      dst <= '0;
      src <= '0;
      ethertype <= '0;
      tci <= '0;
      vlan <= 1'b0;
      len <= '0;
      seq <= '0;
    end else begin
      state <= state_n;
      frame_done <= fin;
      gap_cnt <= state == GAP ? gap_cnt - 16'd1 : GAP_LOAD;
      if (fin) seq_num <= seq_num + 32'd1;
      if (launch) begin
        dst <= cfg_dst_mac;
        src <= cfg_src_mac;
        ethertype <= cfg_ethertype;
        tci <= cfg_vlan_tci;
        vlan <= cfg_vlan_en;
        len <= len_c;
        last_beat <= len_m1[10:5];
        seq <= fin ? seq_num + 32'd1 : seq_num;
        beat <= '0;
      end else if (hs) begin
        beat <= beat + 6'd1;
      end
    end
  end
  assign m_axis_tvalid = state == SEND;
  assign busy = state != IDLE;
  assign m_axis_tlast = m_axis_tvalid && beat == last_beat;
  assign m_axis_tkeep = !m_axis_tvalid ? '0 : (!m_axis_tlast || len[4:0] == 5'd0) ? '1 : (32'd1 << len[4:0]) - 32'd1;
  assign hdr = vlan ? {dst, src, 16'h8100, tci, ethertype, seq, 80'h0} : {dst, src, ethertype, seq, 112'h0};
  assign hdr_len = vlan ? 11'd22 : 11'd18;
  for (genvar i = 0; i < 32; i++) begin : g_byte
    logic [10:0] b;
    assign b = {beat, 5'(i)};
    assign m_axis_tdata[8*i +: 8] = (!m_axis_tvalid || b >= len) ? 8'h00 :
                                    b < hdr_len ? hdr[8*(31 - int'(b[4:0])) +: 8] : b[7:0];
  end
endmodule
